ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide engine in the EX stage. It consumes operands and control from the ID/EX pipeline register outputs and returns a result toward EX/MEM.
- While it is busy, it back-pressures the ID/EX register and the front end through busy_o. This makes it the consuming end of the ID/EX interface, with a valid/ready handshake.
- Uses a shift-add multiply and a restoring divide, one bit per cycle, and follows RV32M result semantics.

Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- CNT_W, 5, iteration counter width (2^CNT_W == XLEN)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-low
- valid_i  in  1  ID/EX holds a mul/div op for this unit
- ready_o  out  1  unit can accept an op (state IDLE)
- flush_i  in  1  abort in-flight op
- op_i  in  3  000 MUL, 001 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; others reserved
- rsData_i  in  32  operand A (multiplicand / dividend)
- rtData_i  in  32  operand B (multiplier / divisor)
- wbAddr_i  in  5  destination register
- regWrite_i  in  1  write-back enable carried with the op
- busy_o  out  1  stall request to hazard logic (state != IDLE and state != DONE)
- valid_o  out  1  result valid, one-cycle pulse
- result_o  out  32  result
- wbAddr_o  out  5  captured destination
- regWrite_o  out  1  captured write-back enable, qualified by valid_o

Behaviour:
- Reset (rst_i==0 at a rising edge): state=IDLE, counter=0, all internal accumulators=0, valid_o=0, result_o=0, wbAddr_o=0, regWrite_o=0. Reset mid-operation aborts with no valid_o. ready_o=1 after reset.
- States:
  - IDLE: ready_o=1. Accept when valid_i&ready_o: latch op, operands, wbAddr and regWrite; take absolute values for signed DIV/REM; go to CALC with counter=0.
  - CALC: one iteration per cycle. Counter increments; at counter==31 the final iteration is done, the sign-corrected result is registered into result_o, and state goes to DONE.
  - DONE: valid_o=1 for exactly this cycle; ready_o=0; next state IDLE.
- Latency: accept at edge E0; valid_o high in the cycle following edge E32, i.e. 33 cycles. A back-to-back op can be accepted at the edge that leaves DONE+1 (IDLE cycle); throughput is 1 op per 34 cycles.
- Divide-by-zero (rtData_i==0 with op DIV/DIVU/REM/REMU): detected in IDLE, skip CALC, go directly to DONE (valid_o one cycle after acceptance). DIV/DIVU give 0xFFFFFFFF; REM/REMU give rsData_i unchanged.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM gives 0. This must fall out of the magnitude path, not a special case.
- Sign rules: quotient is negated iff the operand signs differ; remainder takes the dividend's sign. MUL returns the low 32 bits of the unsigned product (identical for signed). MULHU returns the high 32 bits of the unsigned 64-bit product.
- Reserved op_i: treated as MUL.
- flush_i:
  - In CALC: returns to IDLE at the next edge, with no valid_o and outputs held.
  - In IDLE together with valid_i: no accept.
  - In DONE: ignored; the result is still delivered.
- Priority at an edge: rst_i > flush_i > normal transition.
- valid_i in CALC/DONE is ignored; the upstream register holds because busy_o is asserted.
- result_o, wbAddr_o and regWrite_o hold their last values outside DONE. regWrite_o=regWrite_captured & (state==DONE).

Test Plan:
- Reset, then MUL 7×6 → ready_o=0 next cycle; busy_o=1 for 32 cycles; valid_o=1 exactly once at cycle 33; result_o=42; wbAddr_o echoes 5'd9; then ready_o=1.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → result 0xFFFFFFFE. MUL on the same operands → 0x00000001.
- DIV -7/2 → 0xFFFFFFFD (-3). REM -7/2 → 0xFFFFFFFF (-1). DIVU 100/7 → 14. REMU 100/7 → 2.
- Divide-by-zero: DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5; valid_o asserts 1 cycle after accept; busy_o never asserts.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Abort cases:
  - flush_i at CALC cycle 10 → IDLE next cycle, no valid_o, ready_o=1.
  - rst_i=0 at CALC cycle 20 → all outputs 0 next cycle.
  - A following DIVU 9/3 → 3 at correct latency.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit (RV32M semantics).
// Shift-add multiply and restoring divide, one bit per cycle, with a
// valid/ready intake from the ID/EX register and a one-cycle result pulse.
module ex_muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rsData_i,
  input  logic [XLEN-1:0] rtData_i,
  input  logic [4:0]      wbAddr_i,
  input  logic            regWrite_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      wbAddr_o,
  output logic            regWrite_o
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  // r_acc: product high half (mul) or partial remainder (div)
  // r_q:   multiplier shifting out (mul) or dividend shifting into quotient (div)
  logic [XLEN-1:0]   r_acc;
  logic [XLEN-1:0]   r_q;
  logic [XLEN-1:0]   r_opnd;
  logic              r_is_div;
  logic              r_is_rem;
  logic              r_is_hi;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [4:0]        r_wbaddr;
  logic              r_regwrite;

  logic              r_ready;
  logic              r_busy;
  logic              r_valid;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_wbaddr_o;
  logic              r_regwrite_o;

  logic              w_is_div;
  logic              w_signed;
  logic              w_div_zero;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [XLEN-1:0]   w_zero_result;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_sh;
  logic [XLEN:0]     w_div_diff;
  logic [XLEN-1:0]   w_acc_nxt;
  logic [XLEN-1:0]   w_q_nxt;
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;
  logic [XLEN-1:0]   w_result;

  // Intake decode: operand magnitudes and the divide-by-zero shortcut
  always_comb begin
    w_is_div      = op_i[2];
    w_signed      = op_i[2] & ~op_i[0];
    w_div_zero    = w_is_div && (rtData_i == '0);
    w_abs_a       = (w_signed && rsData_i[XLEN-1]) ? -rsData_i : rsData_i;
    w_abs_b       = (w_signed && rtData_i[XLEN-1]) ? -rtData_i : rtData_i;
    w_zero_result = op_i[1] ? rsData_i : '1;
  end

  // One iteration of shift-add multiply or restoring divide, plus final sign fix
  always_comb begin
    w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opnd} : '0);
    w_div_sh   = {r_acc, r_q[XLEN-1]};
    w_div_diff = w_div_sh - {1'b0, r_opnd};
    w_acc_nxt  = w_mul_sum[XLEN:1];
    w_q_nxt    = {w_mul_sum[0], r_q[XLEN-1:1]};
    if (r_is_div) begin
      if (!w_div_diff[XLEN]) begin
        w_acc_nxt = w_div_diff[XLEN-1:0];
        w_q_nxt   = {r_q[XLEN-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_div_sh[XLEN-1:0];
        w_q_nxt   = {r_q[XLEN-2:0], 1'b0};
      end
    end
    w_q_fix = r_neg_q ? -w_q_nxt : w_q_nxt;
    w_r_fix = r_neg_r ? -w_acc_nxt : w_acc_nxt;
    if (r_is_div) begin
      w_result = r_is_rem ? w_r_fix : w_q_fix;
    end else begin
      w_result = r_is_hi ? w_acc_nxt : w_q_nxt;
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_q          <= '0;
      r_opnd       <= '0;
      r_is_div     <= 1'b0;
      r_is_rem     <= 1'b0;
      r_is_hi      <= 1'b0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_wbaddr     <= '0;
      r_regwrite   <= 1'b0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_wbaddr_o   <= '0;
      r_regwrite_o <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid_i && r_ready && !flush_i) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_is_div   <= w_is_div;
            r_is_rem   <= op_i[2] & op_i[1];
            r_is_hi    <= (op_i == 3'b001);
            r_neg_q    <= w_signed & (rsData_i[XLEN-1] ^ rtData_i[XLEN-1]);
            r_neg_r    <= w_signed & rsData_i[XLEN-1];
            r_opnd     <= w_is_div ? w_abs_b : rsData_i;
            r_q        <= w_is_div ? w_abs_a : rtData_i;
            r_wbaddr   <= wbAddr_i;
            r_regwrite <= regWrite_i;
            r_ready    <= 1'b0;
            if (w_div_zero) begin
              r_state      <= S_DONE;
              r_valid      <= 1'b1;
              r_result     <= w_zero_result;
              r_wbaddr_o   <= wbAddr_i;
              r_regwrite_o <= regWrite_i;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_ITER) begin
              r_state      <= S_DONE;
              r_busy       <= 1'b0;
              r_valid      <= 1'b1;
              r_result     <= w_result;
              r_wbaddr_o   <= r_wbaddr;
              r_regwrite_o <= r_regwrite;
            end
          end
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_ready      <= 1'b1;
          r_regwrite_o <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o    = r_ready;
  assign busy_o     = r_busy;
  assign valid_o    = r_valid;
  assign result_o   = r_result;
  assign wbAddr_o   = r_wbaddr_o;
  assign regWrite_o = r_regwrite_o;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed RV32M cases, abort cases and random ops
// compared against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic        flush_i;
  logic [2:0]  op_i;
  logic [31:0] rsData_i;
  logic [31:0] rtData_i;
  logic [4:0]  wbAddr_i;
  logic        regWrite_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  wbAddr_o;
  logic        regWrite_o;

  int npass  = 0;
  int ntotal = 0;
  logic [31:0] last_exp = '0;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .flush_i    (flush_i),
    .op_i       (op_i),
    .rsData_i   (rsData_i),
    .rtData_i   (rtData_i),
    .wbAddr_i   (wbAddr_i),
    .regWrite_i (regWrite_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .wbAddr_o   (wbAddr_o),
    .regWrite_o (regWrite_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: RV32M results straight from 64-bit / signed integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint unsigned p;
    int sa;
    int sb;
    bit ovf;
    p   = 64'(a) * 64'(b);
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b001: return p[63:32];
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      3'b111: return (b == 0) ? a : a % b;
      default: return p[31:0];
    endcase
  endfunction

  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wb, input logic rw);
    @(negedge clk_i);
    op_i = op; rsData_i = a; rtData_i = b; wbAddr_i = wb; regWrite_i = rw; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; rsData_i = $urandom; rtData_i = $urandom; wbAddr_i = 5'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wb, input logic rw);
    logic [31:0] exp;
    bit dz;
    int cyc;
    int busy_n;
    exp = ref_model(op, a, b);
    dz  = op[2] && (b == 0);
    drive_op(op, a, b, wb, rw);
    check({tag, ".ready_after_accept"}, 64'(ready_o), 64'(0));
    cyc = 1;
    busy_n = 0;
    while (!valid_o && cyc < 60) begin
      if (busy_o) busy_n++;
      @(posedge clk_i); #1;
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), dz ? 64'(1) : 64'(33));
    check({tag, ".busy_cycles"}, 64'(busy_n), dz ? 64'(0) : 64'(32));
    check({tag, ".result"}, 64'(result_o), 64'(exp));
    check({tag, ".wbaddr"}, 64'(wbAddr_o), 64'(wb));
    check({tag, ".regwrite"}, 64'(regWrite_o), 64'(rw));
    @(posedge clk_i); #1;
    check({tag, ".valid_pulse"}, 64'(valid_o), 64'(0));
    check({tag, ".ready_again"}, 64'(ready_o), 64'(1));
    check({tag, ".regwrite_drop"}, 64'(regWrite_o), 64'(0));
    check({tag, ".result_hold"}, 64'(result_o), 64'(exp));
    last_exp = exp;
  endtask

  initial begin
    int vcount;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;
    rst_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0; op_i = '0;
    rsData_i = '0; rtData_i = '0; wbAddr_i = '0; regWrite_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("reset.ready", 64'(ready_o), 64'(1));
    check("reset.busy", 64'(busy_o), 64'(0));
    check("reset.valid", 64'(valid_o), 64'(0));
    check("reset.result", 64'(result_o), 64'(0));
    check("reset.wbaddr", 64'(wbAddr_o), 64'(0));
    check("reset.regwrite", 64'(regWrite_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b1;

    // Directed arithmetic cases
    run_op("mul_7x6", 3'b000, 32'd7, 32'd6, 5'd9, 1'b1);
    check("mul_7x6.value", 64'(last_exp), 64'(42));
    run_op("mulhu_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1);
    run_op("mul_ff", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd7, 1'b1);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd8, 1'b1);
    run_op("div_5_0", 3'b100, 32'd5, 32'd0, 5'd10, 1'b1);
    run_op("remu_5_0", 3'b111, 32'd5, 32'd0, 5'd11, 1'b1);
    run_op("rem_m5_0", 3'b110, 32'hFFFF_FFFB, 32'd0, 5'd12, 1'b0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1);
    run_op("reserved_op", 3'b011, 32'd1234, 32'd5678, 5'd15, 1'b1);

    // Flush in CALC: back to IDLE, no result, outputs held
    drive_op(3'b000, 32'd11, 32'd13, 5'd20, 1'b1);
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check("flush_calc.ready", 64'(ready_o), 64'(1));
    check("flush_calc.busy", 64'(busy_o), 64'(0));
    check("flush_calc.result_hold", 64'(result_o), 64'(last_exp));
    vcount = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (valid_o) vcount++;
    end
    check("flush_calc.no_valid", 64'(vcount), 64'(0));

    // Flush together with valid in IDLE: nothing is accepted
    @(negedge clk_i);
    op_i = 3'b101; rsData_i = 32'd50; rtData_i = 32'd5; valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    check("flush_idle.ready", 64'(ready_o), 64'(1));
    check("flush_idle.busy", 64'(busy_o), 64'(0));
    vcount = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (valid_o) vcount++;
    end
    check("flush_idle.no_valid", 64'(vcount), 64'(0));

    // Reset in the middle of CALC: all outputs clear, no result
    drive_op(3'b100, 32'd1000, 32'd7, 5'd21, 1'b1);
    repeat (19) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst_mid.ready", 64'(ready_o), 64'(1));
    check("rst_mid.busy", 64'(busy_o), 64'(0));
    check("rst_mid.valid", 64'(valid_o), 64'(0));
    check("rst_mid.result", 64'(result_o), 64'(0));
    check("rst_mid.wbaddr", 64'(wbAddr_o), 64'(0));
    check("rst_mid.regwrite", 64'(regWrite_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b1;
    run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 5'd22, 1'b1);

    // Randomized ops including edge operands
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 5'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
